// File: rtl/ex_mem_flags.sv
// EX/MEM pipeline register with the architectural Z/N/V flag register.
// Resolves conditional branches in EX against the flags written by older
// instructions and hands the registered outcome to the MEM stage.
module ex_mem_flags #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [WIDTH-1:0]    alu_dst,
    input  logic                alu_ov,
    input  logic                alu_zr,
    input  logic                ex_set_znv,
    input  logic                ex_set_z,
    input  logic                ex_br,
    input  logic [2:0]          ex_cond,
    input  logic [WIDTH-1:0]    ex_br_target,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_we,
    input  logic                ex_mem_re,
    input  logic                ex_mem_we,
    input  logic [WIDTH-1:0]    ex_store_data,
    output logic                mem_valid,
    output logic                mem_we,
    output logic                mem_re,
    output logic                mem_wr,
    output logic [REG_BITS-1:0] mem_rd,
    output logic [WIDTH-1:0]    mem_result,
    output logic [WIDTH-1:0]    mem_store_data,
    output logic                mem_br_taken,
    output logic [WIDTH-1:0]    mem_br_target,
    output logic                flag_z,
    output logic                flag_n,
    output logic                flag_v
);

    // Branch condition decode against a flag set.
    function automatic logic cond_eval(input logic [2:0] cond,
                                       input logic z, input logic n, input logic v);
        logic t;
        case (cond)
            3'b000:  t = ~z;
            3'b001:  t = z;
            3'b010:  t = ~z & ~n;
            3'b011:  t = n;
            3'b100:  t = z | ~n;
            3'b101:  t = n | z;
            3'b110:  t = v;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

    logic                valid_q, valid_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                wr_q, wr_d;
    logic [REG_BITS-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [WIDTH-1:0]    store_data_q, store_data_d;
    logic                br_taken_q, br_taken_d;
    logic [WIDTH-1:0]    br_target_q, br_target_d;
    logic                flag_z_q, flag_z_d;
    logic                flag_n_q, flag_n_d;
    logic                flag_v_q, flag_v_d;
    logic                accept;
    logic                cond_true;
    logic signed [WIDTH-1:0] alu_dst_s;

    assign alu_dst_s = alu_dst;

    // Next-state: bubble on flush or empty EX, hold on stall, else capture EX.
    always_comb begin
        valid_d      = valid_q;
        we_d         = we_q;
        re_d         = re_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        result_d     = result_q;
        store_data_d = store_data_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        flag_z_d     = flag_z_q;
        flag_n_d     = flag_n_q;
        flag_v_d     = flag_v_q;

        accept    = ex_valid & ~stall & ~flush;
        // Flags seen here are those committed by older instructions; the
        // flag write of the previous instruction has already landed.
        cond_true = cond_eval(ex_cond, flag_z_q, flag_n_q, flag_v_q);

        if (flush || (!stall && !ex_valid)) begin
            // Bubble: controls cleared, data fields keep their stale contents.
            valid_d    = 1'b0;
            we_d       = 1'b0;
            re_d       = 1'b0;
            wr_d       = 1'b0;
            br_taken_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            we_d         = ex_we & (ex_rd != '0);
            re_d         = ex_mem_re;
            wr_d         = ex_mem_we;
            rd_d         = ex_rd;
            result_d     = alu_dst;
            store_data_d = ex_store_data;
            br_taken_d   = ex_br & cond_true;
            br_target_d  = ex_br_target;
        end

        // Branches never write flags even if a set bit is wrongly asserted.
        if (accept && !ex_br) begin
            if (ex_set_znv) begin
                flag_z_d = alu_zr;
                flag_n_d = alu_dst_s < 0;
                flag_v_d = alu_ov;
            end else if (ex_set_z) begin
                flag_z_d = alu_zr;
            end
        end
    end

    // State registers with synchronous reset clearing every output and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= '0;
            result_q     <= '0;
            store_data_q <= '0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_v_q     <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            we_q         <= we_d;
            re_q         <= re_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            store_data_q <= store_data_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
            flag_v_q     <= flag_v_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_we         = we_q;
    assign mem_re         = re_q;
    assign mem_wr         = wr_q;
    assign mem_rd         = rd_q;
    assign mem_result     = result_q;
    assign mem_store_data = store_data_q;
    assign mem_br_taken   = br_taken_q;
    assign mem_br_target  = br_target_q;
    assign flag_z         = flag_z_q;
    assign flag_n         = flag_n_q;
    assign flag_v         = flag_v_q;

endmodule

// File: doc/ex_mem_flags.md
Name: ex_mem_flags

Overview:
- Stage directly downstream of the ALU. Captures ALU result and ov/zr into the EX/MEM pipeline register.
- Owns the architectural Z/N/V flag register and resolves conditional branches against it.
- Presents registered branch outcome and result to the MEM stage; honours pipeline stall and flush.

Parameters:
- WIDTH, 16, datapath width of result, store data and branch target
- REG_BITS, 4, destination register index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold pipeline register and flags this cycle
- flush  in  1  squash the EX instruction; load a bubble
- ex_valid  in  1  EX holds a real instruction
- alu_dst  in  WIDTH  ALU result
- alu_ov  in  1  ALU overflow
- alu_zr  in  1  ALU zero
- ex_set_znv  in  1  instruction updates Z, N, V (ADD/SUB)
- ex_set_z  in  1  instruction updates Z only (AND/NOR/shifts)
- ex_br  in  1  conditional branch in EX
- ex_cond  in  3  branch condition code
- ex_br_target  in  WIDTH  branch target PC
- ex_rd  in  REG_BITS  destination register
- ex_we  in  1  register write enable
- ex_mem_re  in  1  load
- ex_mem_we  in  1  store
- ex_store_data  in  WIDTH  store data
- mem_valid, mem_we, mem_re, mem_wr  out  1 each  registered controls
- mem_rd  out  REG_BITS  registered destination
- mem_result  out  WIDTH  registered ALU result / address
- mem_store_data  out  WIDTH  registered store data
- mem_br_taken  out  1  registered branch-taken
- mem_br_target  out  WIDTH  registered target
- flag_z, flag_n, flag_v  out  1 each  architectural flags

Behaviour:
- Reset is synchronous, active-high: on a rising edge with rst=1, every output and flag goes to 0. Reset mid-stall or mid-flush still clears everything. Priority is rst > flush > stall > normal.
- Accept condition: accept = ex_valid & ~stall & ~flush. Latency is 1 cycle from EX inputs to mem_* outputs.
- Normal capture:
  - Pipeline register loads all ex_* inputs.
  - mem_result = alu_dst.
  - mem_we = ex_we & (ex_rd != 0); a write to R0 is suppressed.
- Stall: all registers and flags hold. ex_* inputs are ignored and must be re-presented by upstream.
- Flush:
  - Pipeline register loads a bubble: mem_valid = mem_we = mem_re = mem_wr = mem_br_taken = 0. The data fields hold their old values and are don't-care.
  - Flags are not updated.
  - flush together with stall behaves as flush.
- ex_valid=0 without stall/flush: a bubble is loaded, exactly as for flush.
- Flag update on accept only:
  - ex_set_znv: Z=alu_zr, N=alu_dst[WIDTH-1], V=alu_ov.
  - ex_set_z only: Z=alu_zr; N and V hold.
  - Both asserted: treated as ex_set_znv.
  - Neither asserted: flags hold.
- Branch resolution:
  - Evaluated combinationally in EX from the current flag register, i.e. the flags written by older instructions.
  - The result is registered into mem_br_taken = accept & ex_br & cond_true.
  - mem_br_target is loaded on every accept.
- Condition codes (cond_true):
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 and N=0
  - 011: N=1
  - 100: Z=1 or N=0
  - 101: N=1 or Z=1
  - 110: V=1
  - 111: always
- Back-to-back hazard: a flag-setting instruction accepted in cycle t, followed by a branch in EX in cycle t+1, sees the updated flags. No forwarding path is needed because flags write at the edge ending cycle t.
- Branches never update flags, even when ex_set_z or ex_set_znv is wrongly asserted together with ex_br; ex_br wins.
- The block never generates flush itself. The MEM/hazard unit uses mem_br_taken to flush upstream.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs → all mem_*, flags = 0. Deassert, then ADD with alu_dst=16'h0005, ov=0, zr=0, ex_rd=3, we=1 → next cycle mem_result=0005, mem_rd=3, mem_we=1, Z=N=V=0.
- Flag scoping: SUB with alu_dst=16'h8000, ov=1 → Z=0, N=1, V=1. Then AND with alu_dst=0, zr=1, ex_set_z → Z=1, N=1, V=1 retained.
- Branch conditions: with flags Z=0, N=1, V=0, issue branches with cond 000..111, target 16'h0040 → mem_br_taken = 1,0,0,1,0,1,0,1 respectively; mem_br_target=0040.
- Stall/flush: ADD (zr=1, set_znv) held with stall=1 for 3 cycles → mem_* and flags unchanged. Release → captured, Z=1. Next, flush=1 together with a taken cond=111 branch → mem_valid=0, mem_br_taken=0, flags unchanged.
- R0 and hazard:
  - ex_rd=0, ex_we=1 → mem_we=0.
  - ADD setting Z=1, then a cond=001 branch in the very next cycle → mem_br_taken=1.
  - rst asserted during stall → all cleared next edge.
